fifo_wr_ctrl: RTL and testbench
===============================

// Module: fifo_wr_ctrl
// PURPOSE
//  Write-side controller of the ASYNC_FIFO, the counterpart of the read-side pointer/empty logic.
//  Keeps the binary and Gray write pointers and drives the dual-port memory write address and enable.
//  Synchronizes the read-domain Gray pointer into wclk (2-FF) to produce full, almost-full and fill level.
//  Also keeps a sticky overflow flag. Sits between the TX-side producer and the FIFO memory.
// PARAMETERS
//  ADDR_W     3  memory address width; depth = 2**ADDR_W, pointers are ADDR_W+1 bits
//  AFULL_TH   6  wafull asserts when wlevel >= AFULL_TH (1..2**ADDR_W)
// PORTS
//  wclk         in   1         write-domain clock, all state on rising edge
//  wrst         in   1         synchronous active-high reset
//  winc         in   1         write request; data accepted on this edge when wfull=0
//  wrptr_async  in   ADDR_W+1  read-domain Gray read pointer, unsynchronized
//  wovf_clr     in   1         clears sticky overflow flag
//  wclken       out  1         memory write enable = winc & ~wfull (combinational)
//  waddr        out  ADDR_W    memory write address, registered
//  wptr         out  ADDR_W+1  registered Gray write pointer, sent to the read domain
//  wfull        out  1         FIFO full (combinational from registers)
//  wafull       out  1         almost full (combinational from registers)
//  wlevel       out  ADDR_W+1  entries in FIFO as seen from wclk, 0..2**ADDR_W
//  wovf         out  1         sticky: a write was attempted while full
// BEHAVIOUR
//  Reset (wrst=1 at edge): wbin, wptr, waddr, both sync stages and wovf go to 0.
//   Hence wfull=0, wlevel=0 and wafull=0. wrst overrides every other input, mid-operation included.
//  Synchronizer: wq1 <= wrptr_async, wq2 <= wq1. Only wq2 is used.
//   A read-pointer change reaches wfull/wlevel 2 wclk edges after it is sampled.
//  Write (winc=1 and wfull=0): wbin <= wbin+1, wptr <= bin2gray(wbin+1), waddr <= (wbin+1)[ADDR_W-1:0].
//   waddr always equals wbin[ADDR_W-1:0]. Memory writes at current waddr on the same edge that wclken=1.
//  Blocked write (winc=1 and wfull=1): pointers and waddr hold, wclken=0, wovf <= 1.
//  wovf_clr=1: wovf <= 0. Set wins when set and clear fall on the same edge.
//  bin2gray(b) = b ^ (b>>1). Pointers wrap modulo 2**(ADDR_W+1), no saturation.
//  wfull = (wptr == {~wq2[ADDR_W:ADDR_W-1], wq2[ADDR_W-2:0]}).
//  wlevel = (wbin - gray2bin(wq2)) mod 2**(ADDR_W+1). Pessimistic: never below true occupancy.
//  wafull = (wlevel >= AFULL_TH). wfull implies wafull and wlevel = 2**ADDR_W.
//  Simultaneous write and read-pointer advance: the write uses the current wfull.
//   The freed slot is seen 2 edges later. No write is ever lost without wovf being set.
//  No FSM. State is wbin, wptr, waddr, wq1, wq2 and wovf. wptr changes by at most 1 bit per edge.
// TESTING (ADDR_W=3, AFULL_TH=6)
//  1 Reset: wrst=1 for 2 edges with winc=1 -> wptr=0, waddr=0, wfull=0, wafull=0, wlevel=0, wovf=0.
//  2 Fill: wrptr_async=0, winc=1 for 8 edges.
//    -> wptr 1,3,2,6,7,5,4,C; waddr 1..7,0.
//    -> wafull=1 after the 6th write, wfull=1 and wlevel=8 after the 8th.
//  3 Overflow: from full, winc=1 one edge -> wclken=0, wptr stays 4'hC, wovf=1.
//    Then wovf_clr=1 -> wovf=0. Repeat with winc and wovf_clr together -> wovf=1.
//  4 Drain: from full, wrptr_async=4'h1.
//    -> wfull stays 1 for exactly 2 edges, then wfull=0 and wlevel=7.
//    -> next winc gives wclken=1.
//  5 Wrap: 20 writes with the reader trailing by 2 entries.
//    -> wptr passes C->D->...->8->0, waddr 7->0, no false wfull, wlevel <= 4 throughout.
//  6 Reset mid-fill: after 5 writes, wrst=1 with winc=1 -> all outputs return to reset values the next edge.

Source files
------------

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side port bundle of the async FIFO: producer handshake, read-pointer input,
// memory write controls and status flags.
interface fifo_wr_ctrl_if #(
   parameter int ADDR_W = 3
);
   logic              winc;
   logic [ADDR_W:0]   wrptr_async;
   logic              wovf_clr;
   logic              wclken;
   logic [ADDR_W-1:0] waddr;
   logic [ADDR_W:0]   wptr;
   logic              wfull;
   logic              wafull;
   logic [ADDR_W:0]   wlevel;
   logic              wovf;

   modport master (
      output winc, wrptr_async, wovf_clr,
      input  wclken, waddr, wptr, wfull, wafull, wlevel, wovf
   );

   modport slave (
      input  winc, wrptr_async, wovf_clr,
      output wclken, waddr, wptr, wfull, wafull, wlevel, wovf
   );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the async FIFO: binary/Gray write pointers, memory write
// address/enable, 2-FF read-pointer synchronizer, full/almost-full/level and sticky overflow.
module fifo_wr_ctrl #(
   parameter int ADDR_W   = 3,
   parameter int AFULL_TH = 6
) (
   input logic           wclk,
   input logic           wrst,
   fifo_wr_ctrl_if.slave bus
);
   localparam logic [ADDR_W:0] AFULL_V = AFULL_TH[ADDR_W:0];

   logic [ADDR_W:0]   wbin_q,  wbin_d;
   logic [ADDR_W:0]   wptr_q,  wptr_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [ADDR_W:0]   wq1_q,   wq1_d;
   logic [ADDR_W:0]   wq2_q,   wq2_d;
   logic              wovf_q,  wovf_d;

   logic [ADDR_W:0]   wbin_inc;
   logic [ADDR_W:0]   rbin_sync;
   logic [ADDR_W:0]   wlevel;
   logic              wfull;
   logic              wclken;

   function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
      logic [ADDR_W:0] b;
      b = g;
      for (int unsigned i = 1; i <= ADDR_W; i++) begin
         b = b ^ (g >> i);
      end
      return b;
   endfunction

   // Full when the Gray pointers differ only in their two MSBs (one full lap apart).
   always_comb begin
      wfull     = (wptr_q == {~wq2_q[ADDR_W:ADDR_W-1], wq2_q[ADDR_W-2:0]});
      rbin_sync = gray2bin(wq2_q);
      wlevel    = wbin_q - rbin_sync;
      wclken    = bus.winc & ~wfull;
      wbin_inc  = wbin_q + 1'b1;
   end

   always_comb begin
      wbin_d  = wbin_q;
      wptr_d  = wptr_q;
      waddr_d = waddr_q;
      wq1_d   = bus.wrptr_async;
      wq2_d   = wq1_q;
      wovf_d  = wovf_q;
      if (wclken) begin
         wbin_d  = wbin_inc;
         wptr_d  = wbin_inc ^ (wbin_inc >> 1);
         waddr_d = wbin_inc[ADDR_W-1:0];
      end
      // A blocked write sets the flag even when a clear arrives on the same edge.
      if (bus.winc && wfull) begin
         wovf_d = 1'b1;
      end else if (bus.wovf_clr) begin
         wovf_d = 1'b0;
      end
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         wbin_q  <= '0;
         wptr_q  <= '0;
         waddr_q <= '0;
         wq1_q   <= '0;
         wq2_q   <= '0;
         wovf_q  <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wptr_q  <= wptr_d;
         waddr_q <= waddr_d;
         wq1_q   <= wq1_d;
         wq2_q   <= wq2_d;
         wovf_q  <= wovf_d;
      end
   end

   assign bus.wclken = wclken;
   assign bus.waddr  = waddr_q;
   assign bus.wptr   = wptr_q;
   assign bus.wfull  = wfull;
   assign bus.wafull = (wlevel >= AFULL_V);
   assign bus.wlevel = wlevel;
   assign bus.wovf   = wovf_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl (ADDR_W=3, AFULL_TH=6) against a count-based model.
module tb_fifo_wr_ctrl;
   logic wclk = 1'b0;
   logic wrst;

   fifo_wr_ctrl_if #(.ADDR_W(3)) bus ();

   fifo_wr_ctrl #(.ADDR_W(3), .AFULL_TH(6)) dut (
      .wclk (wclk),
      .wrst (wrst),
      .bus  (bus)
   );

   always #5 wclk = ~wclk;

   int checks   = 0;
   int failures = 0;

   // Model: total writes accepted, reader position, and reader position as seen 1 and 2 edges late.
   int W, R, q1, q2;
   bit ovf;
   bit cur_winc, cur_clr, cur_rst;
   logic [14:0] e, o;

   function automatic logic [3:0] gray4(input int v);
      logic [3:0] b;
      b = 4'(v & 15);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [14:0] expv();
      int  lvl;
      bit  full;
      lvl  = W - q2;
      full = (lvl == 8);
      return {cur_winc & ~full, gray4(W), 3'(W & 7), full, (lvl >= 6), 4'(lvl), ovf};
   endfunction

   function automatic logic [14:0] obs();
      return {bus.wclken, bus.wptr, bus.waddr, bus.wfull, bus.wafull, bus.wlevel, bus.wovf};
   endfunction

   task automatic drive(input bit winc, input bit clr, input bit rst);
      cur_winc        = winc;
      cur_clr         = clr;
      cur_rst         = rst;
      bus.winc        = winc;
      bus.wovf_clr    = clr;
      bus.wrptr_async = gray4(R);
      wrst            = rst;
      #1;
   endtask

   task automatic step();
      bit full;
      @(posedge wclk);
      if (cur_rst) begin
         W = 0; q1 = 0; q2 = 0; ovf = 0;
      end else begin
         full = ((W - q2) == 8);
         q2 = q1;
         q1 = R;
         if (cur_winc && full) ovf = 1;
         else begin
            if (cur_winc) W++;
            if (cur_clr) ovf = 0;
         end
      end
      @(negedge wclk);
   endtask

   task automatic test_reset();
      R = 0;
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 1);
         step();
      end
      drive(0, 0, 0);
      e = 15'h0;
      o = obs();
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL reset_state got=%h exp=%h", o, e);
      end
   endtask

   task automatic test_fill();
      R = 0;
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 0);
         e = expv(); o = obs();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL fill[%0d] got=%h exp=%h", i, o, e);
         end
         step();
      end
      drive(0, 0, 0);
      checks++;
      if (bus.wptr !== 4'hC || bus.wfull !== 1'b1 || bus.wlevel !== 4'd8) begin
         failures++;
         $display("FAIL fill_full wptr=%h wfull=%b wlevel=%0d exp C/1/8", bus.wptr, bus.wfull, bus.wlevel);
      end
   endtask

   task automatic test_overflow();
      bit pat [3][2];
      pat = '{'{1, 0}, '{0, 1}, '{1, 1}};
      for (int i = 0; i < 3; i++) begin
         drive(pat[i][0], pat[i][1], 0);
         e = expv(); o = obs();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL ovf_pre[%0d] got=%h exp=%h", i, o, e);
         end
         step();
         drive(0, 0, 0);
         e = expv(); o = obs();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL ovf_post[%0d] got=%h exp=%h", i, o, e);
         end
      end
      checks++;
      if (bus.wovf !== 1'b1 || bus.wptr !== 4'hC) begin
         failures++;
         $display("FAIL ovf_setwins wovf=%b wptr=%h exp 1/C", bus.wovf, bus.wptr);
      end
   endtask

   task automatic test_drain();
      R = 1;
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0);
         e = expv(); o = obs();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL drain[%0d] got=%h exp=%h", i, o, e);
         end
         step();
      end
      drive(1, 0, 0);
      checks++;
      if (bus.wclken !== 1'b1 || bus.wlevel !== 4'd7 || bus.wfull !== 1'b0) begin
         failures++;
         $display("FAIL drain_wr wclken=%b wlevel=%0d wfull=%b exp 1/7/0", bus.wclken, bus.wlevel, bus.wfull);
      end
      step();
   endtask

   task automatic test_wrap();
      R = 0;
      drive(0, 0, 1);
      step();
      for (int i = 0; i < 20; i++) begin
         R = (W > 2) ? W - 2 : 0;
         drive(1, 0, 0);
         e = expv(); o = obs();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL wrap[%0d] got=%h exp=%h", i, o, e);
         end
         checks++;
         if (bus.wfull !== 1'b0 || bus.wlevel > 4'd4) begin
            failures++;
            $display("FAIL wrap_lvl[%0d] wfull=%b wlevel=%0d exp 0/<=4", i, bus.wfull, bus.wlevel);
         end
         step();
      end
   endtask

   task automatic test_reset_midfill();
      R = 0;
      drive(0, 0, 1);
      step();
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 0);
         step();
      end
      drive(1, 0, 1);
      step();
      drive(0, 0, 0);
      e = 15'h0;
      o = obs();
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL reset_midfill got=%h exp=%h", o, e);
      end
   endtask

   task automatic test_random();
      bit winc, clr, rst;
      for (int i = 0; i < 400; i++) begin
         rst  = ($urandom_range(0, 79) == 0);
         winc = ($urandom_range(0, 3) != 0);
         clr  = ($urandom_range(0, 7) == 0);
         if (rst) R = 0;
         else if (R < W && $urandom_range(0, 1) == 1) R++;
         drive(winc, clr, rst);
         e = expv(); o = obs();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL random[%0d] got=%h exp=%h", i, o, e);
         end
         step();
      end
   endtask

   initial begin
      W = 0; R = 0; q1 = 0; q2 = 0; ovf = 0;
      bus.winc = 1'b0; bus.wovf_clr = 1'b0; bus.wrptr_async = '0; wrst = 1'b1;
      @(negedge wclk);
      test_reset();
      test_fill();
      test_overflow();
      test_drain();
      test_wrap();
      test_reset_midfill();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
